// File: rtl/tt_bus_pkg.sv
// Shared types and field positions for the pin-level bus responder.
// Every block that decodes ui_in or builds uo_out imports this package.
package tt_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RD_SETUP,
    ST_ACK,
    ST_RELEASE
  } state_e;

  localparam int UI_STROBE = 7;
  localparam int UI_RW     = 6;
  localparam int ADDR_HI   = 3;
  localparam int ADDR_LO   = 0;

  localparam int UO_ACK  = 0;
  localparam int UO_BUSY = 1;
  localparam int UO_ERR  = 2;

  localparam logic [3:0] ADDR_ID  = 4'hF;
  localparam int         NUM_REGS = 15;

  function automatic logic [7:0] pack_status(input logic       ack,
                                             input logic       busy,
                                             input logic       err,
                                             input logic [3:0] count);
    logic [7:0] s;
    s          = '0;
    s[UO_ACK]  = ack;
    s[UO_BUSY] = busy;
    s[UO_ERR]  = err;
    s[7:4]     = count;
    return s;
  endfunction

endpackage

// File: rtl/tt_pin_sync.sv
// N-flop synchronizer for a single asynchronous pin.
// Output is the last stage; all stages clear on reset.
module tt_pin_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  // NOTE: state flops use non-blocking assignments so every stage samples the
  // previous stage's old value; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/tt_pin_bus_responder.sv
// Pin-level register responder: 4-phase strobe/ack handshake over ui_in/uio_in,
// 15 R/W registers plus a read-only ID, status and transaction count on uo_out.
module tt_pin_bus_responder
  import tt_bus_pkg::*;
#(
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e     state_q, state_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic [3:0] count_q, count_d;
  logic       drive_q, drive_d;
  logic [7:0] rdata_q, rdata_d;
  logic [3:0] addr_q, addr_d;
  logic       rw_q, rw_d;
  logic [7:0] wdata_q, wdata_d;

  logic       reg_we;
  logic [7:0] regs_q [NUM_REGS];

  logic       ss;
  logic       unused_reserved;

  assign unused_reserved = ^ui_in[5:4];

  tt_pin_sync #(
    .N (SYNC_STAGES)
  ) u_strobe_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ui_in[UI_STROBE]),
    .q     (ss)
  );

  // NOTE: every variable gets its hold value before the case statement, so no
  // path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    err_d   = err_q;
    count_d = count_q;
    drive_d = drive_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    reg_we  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ss) begin
          addr_d  = ui_in[ADDR_HI:ADDR_LO];
          rw_d    = ui_in[UI_RW];
          wdata_d = uio_in;
          busy_d  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (rw_q) begin
          rdata_d = (addr_q == ADDR_ID) ? ID_VALUE : regs_q[addr_q];
          drive_d = 1'b1;
          state_d = ST_RD_SETUP;
        end else begin
          if (addr_q == ADDR_ID) begin
            err_d = 1'b1;
          end else begin
            reg_we = 1'b1;
            // Writing 0x0 with bit 7 set is the software way to clear err.
            if (addr_q == 4'h0 && wdata_q[7]) begin
              err_d = 1'b0;
            end
          end
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_RD_SETUP: begin
        ack_d   = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (!ss) begin
          ack_d   = 1'b0;
          drive_d = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        busy_d  = 1'b0;
        count_d = count_q + 4'd1;
        rdata_d = 8'h00;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Deselect abandons whatever is in flight, including an uncommitted write.
    if (!ena) begin
      state_d = ST_IDLE;
      ack_d   = 1'b0;
      busy_d  = 1'b0;
      drive_d = 1'b0;
      rdata_d = 8'h00;
      err_d   = err_q;
      count_d = count_q;
      reg_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= 4'h0;
      drive_q <= 1'b0;
      rdata_q <= 8'h00;
      addr_q  <= 4'h0;
      rw_q    <= 1'b0;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      count_q <= count_d;
      drive_q <= drive_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
    end
  end

  // NOTE: the register file is built from flops, so it can and must be reset;
  // software relies on every register reading 0 after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (reg_we) begin
      regs_q[addr_q] <= wdata_q;
    end
  end

  assign uo_out  = pack_status(ack_q, busy_q, err_q, count_q);
  assign uio_out = rdata_q;
  assign uio_oe  = {8{drive_q}};

endmodule

// File: tb/tb_tt_pin_bus_responder.sv
// Directed bench for tt_pin_bus_responder: handshake latency, ID/err rules,
// held and aborted strobes, count wrap, deselect and asynchronous reset.
module tb_tt_pin_bus_responder;
  import tt_bus_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int         checks;
  int         errors;
  logic [7:0] rd;

  tt_pin_bus_responder #(
    .ID_VALUE    (8'hA5),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_uo(input int idx, input logic val, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (uo_out[idx] === val) seen = 1'b1;
    end
    check(tag, {7'd0, seen}, 8'h01);
  endtask

  task automatic txn(input logic rw, input logic [3:0] addr, input logic [7:0] wd,
                     output logic [7:0] rdata);
    ui_in  = {1'b1, rw, 2'b00, addr};
    uio_in = wd;
    wait_uo(UO_ACK, 1'b1, "txn_ack_seen");
    rdata = uio_out;
    ui_in = 8'h00;
    wait_uo(UO_BUSY, 1'b0, "txn_done_seen");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    step(3);
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
    step(2);

    // 1: write latency; strobe set here is sampled at edge k.
    ui_in  = 8'h82;
    uio_in = 8'h3C;
    step(3);
    check("wr_k2_status", uo_out, 8'h02);
    step(1);
    check("wr_k3_ack", uo_out, 8'h03);
    check("wr_k3_oe", uio_oe, 8'h00);
    ui_in = 8'h00;
    step(2);
    check("wr_ack_held", uo_out, 8'h03);
    step(1);
    check("wr_ack_fall", uo_out, 8'h02);
    step(1);
    check("wr_count1", uo_out, 8'h10);

    // 1: read latency.
    ui_in = 8'hC2;
    step(3);
    check("rd_k2_oe", uio_oe, 8'h00);
    step(1);
    check("rd_k3_oe", uio_oe, 8'hFF);
    check("rd_k3_data", uio_out, 8'h3C);
    check("rd_k3_noack", uo_out, 8'h12);
    step(1);
    check("rd_k4_ack", uo_out, 8'h13);
    ui_in = 8'h00;
    step(3);
    check("rd_release_status", uo_out, 8'h12);
    check("rd_release_oe", uio_oe, 8'h00);
    step(1);
    check("rd_idle_status", uo_out, 8'h20);
    check("rd_idle_data", uio_out, 8'h00);

    // 2: ID register and sticky err.
    txn(1'b1, 4'hF, 8'h00, rd);
    check("id_read", rd, 8'hA5);
    txn(1'b0, 4'hF, 8'h11, rd);
    check("err_set", {7'd0, uo_out[UO_ERR]}, 8'h01);
    txn(1'b1, 4'hF, 8'h00, rd);
    check("id_reread", rd, 8'hA5);
    check("err_sticky", {7'd0, uo_out[UO_ERR]}, 8'h01);
    txn(1'b0, 4'h0, 8'h80, rd);
    check("err_clear", {7'd0, uo_out[UO_ERR]}, 8'h00);
    txn(1'b1, 4'h0, 8'h00, rd);
    check("reg0_stored", rd, 8'h80);
    check("count7", {4'h0, uo_out[7:4]}, 8'h07);

    // 3: strobe held high after ack yields one transaction.
    ui_in  = 8'h83;
    uio_in = 8'h55;
    wait_uo(UO_ACK, 1'b1, "hold_ack_seen");
    step(20);
    check("hold_ack_stays", {7'd0, uo_out[UO_ACK]}, 8'h01);
    check("hold_count7", {4'h0, uo_out[7:4]}, 8'h07);
    ui_in = 8'h00;
    wait_uo(UO_BUSY, 1'b0, "hold_done_seen");
    check("hold_count8", {4'h0, uo_out[7:4]}, 8'h08);
    txn(1'b1, 4'h3, 8'h00, rd);
    check("hold_reg3", rd, 8'h55);
    for (int i = 0; i < 7; i++) begin
      txn(1'b1, 4'h3, 8'h00, rd);
    end
    check("count_wrap", {4'h0, uo_out[7:4]}, 8'h00);

    // 4: 3-cycle strobe pulse dropped before ack.
    ui_in  = 8'h84;
    uio_in = 8'h5A;
    step(3);
    ui_in = 8'h00;
    step(1);
    check("abort_ack_pulse", {7'd0, uo_out[UO_ACK]}, 8'h01);
    wait_uo(UO_BUSY, 1'b0, "abort_done_seen");
    check("abort_idle", uo_out, 8'h10);
    txn(1'b1, 4'h4, 8'h00, rd);
    check("abort_committed", rd, 8'h5A);

    // 5: deselect during RD_SETUP.
    ui_in = 8'hC2;
    step(4);
    check("ena_rdsetup_oe", uio_oe, 8'hFF);
    ena   = 1'b0;
    ui_in = 8'h00;
    step(1);
    check("ena_oe_off", uio_oe, 8'h00);
    check("ena_status", uo_out, 8'h20);
    step(2);
    ena = 1'b1;
    step(2);
    check("ena_still_idle", uo_out, 8'h20);
    txn(1'b0, 4'h6, 8'h77, rd);
    txn(1'b1, 4'h6, 8'h00, rd);
    check("ena_write_ok", rd, 8'h77);
    check("ena_count4", {4'h0, uo_out[7:4]}, 8'h04);

    // 6: asynchronous reset while acking a read.
    ui_in = 8'hC6;
    step(5);
    check("rst_pre_ack", uo_out, 8'h43);
    check("rst_pre_oe", uio_oe, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_oe", uio_oe, 8'h00);
    check("rst_async_uo", uo_out, 8'h00);
    ui_in = 8'h00;
    step(2);
    rst_n = 1'b1;
    step(1);
    for (int a = 0; a < 15; a++) begin
      txn(1'b1, 4'(a), 8'h00, rd);
      check($sformatf("rst_reg%0d", a), rd, 8'h00);
    end
    txn(1'b1, 4'hF, 8'h00, rd);
    check("rst_id", rd, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
